// File: rtl/ahfp_pkg.sv
// -----------------------------------------------------------------------------
// ahfp_pkg
// Shared definitions for the AHFP arithmetic datapath (adder and multiplier):
// binary32 field widths, exponent bias, canonical special encodings, the
// packed binary32 view and small classification helpers.
// -----------------------------------------------------------------------------
package ahfp_pkg;

   localparam int EXP_W   = 8;
   localparam int MAN_W   = 23;
   localparam int BIAS    = 127;
   localparam int EXP_MAX = 2 * BIAS + 1;   // all-ones exponent: Inf/NaN
   // Working significand: hidden bit, stored fraction, guard, round, sticky.
   localparam int SIG_W   = MAN_W + 4;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp32_t;

   function automatic logic is_nan(input fp32_t f);
      return (f.exp == '1) && (f.man != '0);
   endfunction

   function automatic logic is_inf(input fp32_t f);
      return (f.exp == '1) && (f.man == '0);
   endfunction

endpackage

// File: rtl/ahfp_lzc.sv
// -----------------------------------------------------------------------------
// ahfp_lzc
// Leading-zero counter over the working significand, used to renormalize the
// result of an effective subtraction.
// Ports:
//   i_val  in  SIG_W  significand to scan (MSB = hidden-bit position)
//   o_cnt  out 5      number of leading zeros (SIG_W when i_val is zero)
// -----------------------------------------------------------------------------
module ahfp_lzc
   import ahfp_pkg::*;
(
   input  logic [SIG_W-1:0] i_val,
   output logic [4:0]       o_cnt
);

   // Scanning upward lets the highest set bit make the final assignment.
   always_comb begin
      o_cnt = 5'(SIG_W);
      for (int i = 0; i < SIG_W; i++) begin
         if (i_val[i]) o_cnt = 5'(SIG_W - 1 - i);
      end
   end

endmodule

// File: rtl/ahfp_adder.sv
// -----------------------------------------------------------------------------
// ahfp_adder
// IEEE-754 binary32 adder, round-to-nearest-even, flush-to-zero on subnormal
// inputs and outputs, no exception flags. Result and valid are registered.
// Ports:
//   clk        in  1   clock, rising edge
//   rst_n      in  1   asynchronous active-low reset
//   in_valid   in  1   dataa/datab valid this cycle
//   dataa      in  32  operand A
//   datab      in  32  operand B
//   out_valid  out 1   result valid
//   result     out 32  A+B
// Configuration macro AHFP_ADD_IN_REG_EN: when defined, operands and in_valid
// are registered before the datapath (latency 2); otherwise the datapath feeds
// the output register directly (latency 1).
// -----------------------------------------------------------------------------
module ahfp_adder
   import ahfp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic        out_valid,
   output logic [31:0] result
);

   localparam logic signed [9:0] EXP_SAT = 10'(EXP_MAX);

   fp32_t w_a;
   fp32_t w_b;
   logic  w_vld;

`ifdef AHFP_ADD_IN_REG_EN
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic        r_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_vld <= 1'b0;
      end else begin
         r_a   <= dataa;
         r_b   <= datab;
         r_vld <= in_valid;
      end
   end

   assign w_a   = r_a;
   assign w_b   = r_b;
   assign w_vld = r_vld;
`else
   assign w_a   = dataa;
   assign w_b   = datab;
   assign w_vld = in_valid;
`endif

   // Rounds a normalized {hidden, frac, G, R, S} significand to nearest-even and
   // packs it, saturating to Inf on overflow and flushing to zero on underflow.
   function automatic logic [31:0] round_pack(input logic                    sign,
                                              input logic signed [9:0]       exp,
                                              input logic [SIG_W-1:0]        sig);
      logic                rup;
      logic [MAN_W+1:0]    rnd;
      logic signed [9:0]   e;
      rup = sig[2] & (sig[1] | sig[0] | sig[3]);
      rnd = {1'b0, sig[SIG_W-1:3]} + {{(MAN_W+1){1'b0}}, rup};
      e   = exp;
      if (rnd[MAN_W+1]) begin
         rnd = rnd >> 1;
         e   = e + 10'sd1;
      end
      if (e >= EXP_SAT)     return {sign, POS_INF[30:0]};
      else if (e <= 10'sd0) return {sign, 31'd0};
      else                  return {sign, e[7:0], rnd[MAN_W-1:0]};
   endfunction

   // Exponent zero covers both true zeros and subnormals, which are flushed.
   logic w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
   assign w_a_nan  = is_nan(w_a);
   assign w_b_nan  = is_nan(w_b);
   assign w_a_inf  = is_inf(w_a);
   assign w_b_inf  = is_inf(w_b);
   assign w_a_zero = (w_a.exp == '0);
   assign w_b_zero = (w_b.exp == '0);

   // Exponent and fraction compare as one unsigned field for normal operands.
   fp32_t      w_big;
   fp32_t      w_sml;
   logic [7:0] w_d;
   always_comb begin
      if (w_a[30:0] >= w_b[30:0]) begin
         w_big = w_a;
         w_sml = w_b;
      end else begin
         w_big = w_b;
         w_sml = w_a;
      end
      w_d = w_big.exp - w_sml.exp;
   end

   logic [SIG_W-1:0] w_big_m;
   logic [SIG_W-1:0] w_sml_m;
   logic [SIG_W-1:0] w_sml_sh;
   assign w_big_m = {1'b1, w_big.man, 3'b000};
   assign w_sml_m = {1'b1, w_sml.man, 3'b000};

   // Beyond 25 positions the small operand only ever contributes a sticky bit.
   always_comb begin
      w_sml_sh = {{(SIG_W-1){1'b0}}, 1'b1};
      if (w_d < 8'd26) begin
         w_sml_sh    = w_sml_m >> w_d;
         w_sml_sh[0] = w_sml_sh[0] |
                       (|(w_sml_m & ((27'd1 << w_d) - 27'd1)));
      end
   end

   // Magnitude ordering guarantees the difference never goes negative.
   logic             w_sub;
   logic [SIG_W:0]   w_sum;
   assign w_sub = w_big.sign ^ w_sml.sign;
   assign w_sum = w_sub ? ({1'b0, w_big_m} - {1'b0, w_sml_sh})
                        : ({1'b0, w_big_m} + {1'b0, w_sml_sh});

   logic [4:0] w_lzc;
   ahfp_lzc u_lzc (
      .i_val (w_sum[SIG_W-1:0]),
      .o_cnt (w_lzc)
   );

   logic [SIG_W-1:0]  w_norm;
   logic signed [9:0] w_exp_norm;
   always_comb begin
      if (w_sum[SIG_W]) begin
         // Carry-out: shift right once, folding the dropped bit into sticky.
         w_norm     = {w_sum[SIG_W:2], |w_sum[1:0]};
         w_exp_norm = $signed({2'b00, w_big.exp}) + 10'sd1;
      end else begin
         w_norm     = w_sum[SIG_W-1:0] << w_lzc;
         w_exp_norm = $signed({2'b00, w_big.exp}) - $signed({5'b00000, w_lzc});
      end
   end

   logic [31:0] w_next;
   always_comb begin
      w_next = round_pack(w_big.sign, w_exp_norm, w_norm);
      if (w_a_nan || w_b_nan)                               w_next = QNAN;
      else if (w_a_inf && w_b_inf && (w_a.sign != w_b.sign)) w_next = QNAN;
      else if (w_a_inf)                                      w_next = w_a;
      else if (w_b_inf)                                      w_next = w_b;
      else if (w_a_zero && w_b_zero)                         w_next = {w_a.sign & w_b.sign, 31'd0};
      else if (w_a_zero)                                     w_next = w_b;
      else if (w_b_zero)                                     w_next = w_a;
      else if (w_sum == '0)                                  w_next = '0;
   end

   // Output stage: loaded every cycle; consumers qualify with out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result    <= '0;
         out_valid <= 1'b0;
      end else begin
         result    <= w_next;
         out_valid <= w_vld;
      end
   end

endmodule

// File: tb/tb_ahfp_adder.sv
module tb_ahfp_adder;

`ifdef AHFP_ADD_IN_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] dataa;
   logic [31:0] datab;
   logic        out_valid;
   logic [31:0] result;

   int tests;
   int fails;

   logic [31:0] q_res[$];
   logic        q_vld[$];

   ahfp_adder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .dataa     (dataa),
      .datab     (datab),
      .out_valid (out_valid),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      tests++;
      assert (got === expv) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, got, expv);
      end
   endtask

   // Exact reference: operands become integers on a common scale, the sum is
   // formed exactly, then rounded to 24 significant bits with ties-to-even.
   function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
      logic         sa, sb, s;
      int           ea, eb, emin, p, e, sh;
      logic [319:0] av, bv, mag, q, rem, half;
      sa = a[31];  sb = b[31];
      ea = int'(a[30:23]);  eb = int'(b[30:23]);
      if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC0_0000;
      if (ea == 255 && eb == 255) return (sa != sb) ? 32'h7FC0_0000 : a;
      if (ea == 255) return a;
      if (eb == 255) return b;
      if (ea == 0 && eb == 0) return {sa & sb, 31'd0};
      if (ea == 0) return b;
      if (eb == 0) return a;
      emin = (ea < eb) ? ea : eb;
      av = {296'd0, 1'b1, a[22:0]} << (ea - emin);
      bv = {296'd0, 1'b1, b[22:0]} << (eb - emin);
      if (sa == sb)   begin mag = av + bv; s = sa; end
      else if (av > bv) begin mag = av - bv; s = sa; end
      else if (bv > av) begin mag = bv - av; s = sb; end
      else return 32'h0000_0000;
      p = 0;
      for (int i = 0; i < 320; i++) if (mag[i]) p = i;
      e = p + emin - 23;
      if (p > 23) begin
         sh   = p - 23;
         q    = mag >> sh;
         rem  = mag & ((320'd1 << sh) - 320'd1);
         half = 320'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 320'd1;
         if (q[24]) begin q = q >> 1; e++; end
      end else begin
         q = mag << (23 - p);
      end
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0)   return {s, 31'd0};
      return {s, 8'(e), q[22:0]};
   endfunction

   function automatic logic [31:0] rand_op(input logic [31:0] other);
      logic [31:0] specials [9];
      logic [31:0] x;
      int          e;
      specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                   32'h7FC0_0000, 32'h0040_0000, 32'h7F7F_FFFF, 32'h0080_0000,
                   32'h3F80_0000};
      x = $urandom;
      case ($urandom_range(0, 5))
         0: x = $urandom;
         1, 2: begin
            e = int'(other[30:23]) + int'($urandom_range(0, 6)) - 3;
            if (e < 1) e = 1;
            if (e > 254) e = 254;
            x = {1'($urandom), 8'(e), 23'($urandom)};
         end
         3: x = {~other[31], other[30:3], 3'($urandom)};   // near cancellation
         4: x = specials[$urandom_range(0, 8)];
         default: x = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      endcase
      return x;
   endfunction

   // One clock of streaming: check the output that matured this cycle, then
   // drive the next operand pair and remember what it must produce.
   task automatic step(input logic [31:0] a, input logic [31:0] b, input logic v,
                       input logic [31:0] expv, input string tag);
      logic [31:0] er;
      logic        ev;
      @(negedge clk);
      if (q_res.size() == LAT) begin
         er = q_res.pop_front();
         ev = q_vld.pop_front();
         chk({tag, "_result"}, result, er);
         chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, ev});
      end
      dataa    = a;
      datab    = b;
      in_valid = v;
      q_res.push_back(expv);
      q_vld.push_back(v);
   endtask

   logic [31:0] d_a [16];
   logic [31:0] d_b [16];
   logic [31:0] d_r [16];

   initial begin
      logic [31:0] ra, rb;
      int          n;
      tests = 0;
      fails = 0;
      rst_n = 1'b1;
      in_valid = 1'b0;
      dataa = '0;
      datab = '0;

      d_a = '{32'h3F80_0000, 32'h4040_0000, 32'h43FA_0000, 32'h3F8E_363B,
              32'h42FF_999A, 32'h4040_0000, 32'h7F80_0000, 32'h7F7F_FFFF,
              32'h8000_0000, 32'h0000_0000, 32'h0040_0000, 32'h0080_0000,
              32'h7FC0_0001, 32'hFF80_0000, 32'h7F80_0000, 32'hBF80_0000};
      d_b = '{32'h4000_0000, 32'h4060_0000, 32'h4113_3333, 32'h3AA1_37F4,
              32'h42FC_CCCD, 32'hC040_0000, 32'hFF80_0000, 32'h7F7F_FFFF,
              32'h8000_0000, 32'h8000_0000, 32'h3F80_0000, 32'h8080_0001,
              32'h3F80_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h3F80_0000};
      d_r = '{32'h4040_0000, 32'h40D0_0000, 32'h43FE_999A, 32'h3F8E_5E89,
              32'h437E_3334, 32'h0000_0000, 32'h7FC0_0000, 32'h7F80_0000,
              32'h8000_0000, 32'h0000_0000, 32'h3F80_0000, 32'h8000_0000,
              32'h7FC0_0000, 32'hFF80_0000, 32'h7F80_0000, 32'h0000_0000};

      // Reset state, asserted between clock edges.
      #2 rst_n = 1'b0;
      #1;
      chk("reset_result", result, 32'h0);
      chk("reset_valid", {31'd0, out_valid}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, back to back.
      for (int i = 0; i < 16; i++) step(d_a[i], d_b[i], 1'b1, d_r[i], $sformatf("dir%0d", i));
      repeat (LAT) step(32'h0, 32'h0, 1'b0, 32'h0, "idle");

      // Isolated operation: count cycles until out_valid rises.
      @(negedge clk);
      dataa = 32'h3F80_0000;  datab = 32'h4000_0000;  in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;  dataa = '0;  datab = '0;
      n = 1;
      while (!out_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 32'(n), 32'(LAT));
      chk("latency_result", result, 32'h4040_0000);
      q_res.delete();
      q_vld.delete();

      // Reset in the middle of a stream discards the in-flight sums.
      for (int i = 0; i < 3; i++) begin
         ra = rand_op($urandom);
         rb = rand_op(ra);
         step(ra, rb, 1'b1, ref_add(ra, rb), "prerst");
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("midrst_result", result, 32'h0);
      chk("midrst_valid", {31'd0, out_valid}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      q_res.delete();
      q_vld.delete();
      for (int i = 0; i <= LAT; i++) begin
         @(negedge clk);
         chk("midrst_discard", {31'd0, out_valid}, 32'h0);
      end

      // Randomized stream against the exact reference.
      for (int i = 0; i < 600; i++) begin
         ra = rand_op($urandom);
         rb = rand_op(ra);
         if ($urandom_range(0, 1)) begin
            logic [31:0] t;
            t = ra;  ra = rb;  rb = t;
         end
         step(ra, rb, ($urandom_range(0, 4) != 0), ref_add(ra, rb), "rand");
      end
      repeat (LAT) step(32'h0, 32'h0, 1'b0, 32'h0, "drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
